// File: rtl/fifo_pkg.sv
// Shared defaults and state type for the FIFO write-port arbiter.
package fifo_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: scans upward from the requester after last_gnt.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] idx;

    // First requesting index at offsets 1..NUM_REQ after last_gnt wins; the
    // previous winner is checked last so it only wins when alone.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_gnt} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-oriented arbiter sharing one FIFO write port among NUM_REQ requesters.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant held; round-robin pick registers the next grant
//   BURST | one requester granted; beats pass while FIFO not full
//
// Every release goes through IDLE, so consecutive grants are always separated
// by one idle cycle. ack/wr_en/wr_data/busy are forced low while reset_n is
// low so an in-flight burst cannot write during the reset cycle.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                        clk_wr,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic                        w_full,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        wr_en,
    output logic [DATA_W-1:0]           wr_data,
    output logic                        busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [NUM_REQ-1:0] pick_win;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .win      (pick_win),
        .valid    (pick_valid)
    );

    // Encode the one-hot winner so it can be remembered as the new last_gnt.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Beat accept, FIFO write strobe and data mux from the held grant.
    always_comb begin
        ack     = '0;
        wr_data = '0;
        if (reset_n && (state_q == BURST) && !w_full) begin
            ack = gnt_q & req;
        end
        if (reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_q[i]) begin
                    wr_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
        wr_en = |ack;
        busy  = reset_n && (state_q == BURST);
        gnt   = gnt_q;
    end

    // Next-state: arbitrate in IDLE; release on last beat, burst cap or abandon.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = BURST;
                    gnt_d       = pick_win;
                    last_gnt_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (!(|(gnt_q & req))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if ((|(ack & req_last)) || (burst_cnt_q == CNT_LAST)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; last_gnt resets to the top index so requester 0 wins first.
    always_ff @(posedge clk_wr) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_gnt_q  <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;

    logic            clk_wr = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic            w_full;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk_wr   (clk_wr),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .w_full   (w_full),
        .gnt      (gnt),
        .ack      (ack),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at (last+1), (last+2), ... mod N.
    function automatic int model_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Behavioural model: checks every output each cycle, then advances on the edge's inputs.
    initial begin : model
        bit m_busy;
        int m_owner, m_last, m_cnt, w;
        logic [N-1:0]  e_gnt, e_ack;
        logic          e_busy;
        logic [DW-1:0] e_data;
        m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
        forever begin
            @(negedge clk_wr);
            e_gnt  = m_busy ? N'(1 << m_owner) : '0;
            e_busy = reset_n && m_busy;
            e_ack  = (e_busy && req[m_owner] && !w_full) ? N'(1 << m_owner) : '0;
            e_data = e_busy ? req_data[m_owner*DW +: DW] : '0;
            chk("cyc_gnt", 32'(gnt), 32'(e_gnt));
            chk("cyc_ack", 32'(ack), 32'(e_ack));
            chk("cyc_wr_en", 32'(wr_en), 32'(|e_ack));
            chk("cyc_wr_data", 32'(wr_data), 32'(e_data));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            if (!reset_n) begin
                m_busy = 0; m_last = N - 1; m_cnt = 0;
            end else if (!m_busy) begin
                w = model_pick(req, m_last);
                if (w >= 0) begin
                    m_busy = 1; m_owner = w; m_last = w; m_cnt = 0;
                end
            end else if (!req[m_owner]) begin
                m_busy = 0;
            end else if (e_ack != '0) begin
                if (req_last[m_owner] || m_cnt == MB - 1) m_busy = 0;
                m_cnt++;
            end
        end
    end

    int           wq[$];
    int           wt[$];
    logic [N-1:0] ghist[64];
    int           t_drop;

    // One requester r sends n beats (base, base+1, ...); optional 5-cycle full
    // stall after stall_at beats, optional abandon after drop_at beats; extra
    // requesters hold single-beat requests. Runs 3 cycles past the burst end.
    task automatic run_burst(input int r, input int base, input int n, input bit last_end,
                             input int stall_at, input int drop_at, input logic [N-1:0] extra);
        int k = 0;
        int stall_left = 0;
        bit stalled = 0;
        bit acc = 0;
        int fin = -1;
        bit active;
        wq.delete(); wt.delete(); t_drop = -1;
        for (int t = 0; t < 64; t++) begin
            @(posedge clk_wr); #1;
            if (acc) k++;
            if (stall_at >= 0 && k == stall_at && !stalled) begin
                stalled = 1; stall_left = 5;
            end
            w_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            active = (k < n) && !(drop_at >= 0 && k >= drop_at);
            if (!active && drop_at >= 0 && t_drop < 0) t_drop = t;
            if (!active && fin < 0) fin = t;
            if (fin >= 0 && t == fin + 3) break;
            req = extra; req[r] = active;
            req_last = extra; req_last[r] = last_end && (k == n - 1);
            req_data = '0;
            for (int i = 0; i < N; i++) if (extra[i]) req_data[i*DW +: DW] = DW'(8'hA0 + i);
            req_data[r*DW +: DW] = DW'(base + k);
            @(negedge clk_wr);
            ghist[t] = gnt;
            acc = ack[r] & req[r];
            if (wr_en && gnt[r]) begin
                wq.push_back(int'(wr_data)); wt.push_back(t);
            end
            if (w_full) begin
                chk("stall_gnt", 32'(gnt), 32'(1 << r));
                chk("stall_ack", 32'(ack), 32'h0);
                chk("stall_wr_en", 32'(wr_en), 32'h0);
            end
        end
        if (fin < 0) begin
            chk("burst_timeout", 32'h0, 32'h1);
            @(posedge clk_wr); #1;
        end
        req = '0; req_last = '0; w_full = 1'b0;
    endtask

    task automatic chk_wq(input string name, input int base, input int n);
        chk({name, "_count"}, 32'(wq.size()), 32'(n));
        for (int j = 0; j < n; j++) begin
            chk({name, "_data"}, (j < wq.size()) ? 32'(wq[j]) : 32'hFFFF_FFFF, 32'(base + j));
        end
    endtask

    logic [N-1:0] exp_rr [10] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};

    initial begin : stim
        int k;
        bit acc;
        int rem[N], pos[N], gap[N];
        logic [DW-1:0] base[N];
        logic [N-1:0] accr;

        reset_n = 1'b0; req = 4'hF; req_last = 4'hF; req_data = 32'h3322_1100; w_full = 1'b0;

        // Pin the model's round-robin rule with hand-worked cases.
        chk("pick_1010_after1", 32'(model_pick(4'b1010, 1)), 32'd3);
        chk("pick_1010_after3", 32'(model_pick(4'b1010, 3)), 32'd1);
        chk("pick_0001_after0", 32'(model_pick(4'b0001, 0)), 32'd0);
        chk("pick_none", 32'(model_pick(4'b0000, 2)), 32'hFFFF_FFFF);

        // Reset held with all requesting: no grant, no write.
        repeat (3) begin
            @(posedge clk_wr); #1;
            @(negedge clk_wr);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_wr_en", 32'(wr_en), 32'h0);
        end
        @(posedge clk_wr); #1; reset_n = 1'b1;
        @(negedge clk_wr);
        @(posedge clk_wr); #1;

        // Single-beat bursts from all four: 0,1,2,3,0 with idle gaps.
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(posedge clk_wr); #1;
            end
            if (c == 9) req = '0;
            @(negedge clk_wr);
            chk("rr_gnt", 32'(gnt), 32'(exp_rr[c]));
        end
        @(posedge clk_wr); #1;

        // Burst cap: 12 beats without last from requester 2.
        run_burst(2, 'h10, 12, 1'b0, -1, -1, 4'h0);
        chk_wq("cap", 'h10, 12);
        if (wt.size() >= 9) begin
            chk("cap_back_to_back", 32'(wt[1] - wt[0]), 32'd1);
            chk("cap_release_gap", 32'(wt[8] - wt[7]), 32'd2);
        end else begin
            chk("cap_write_count", 32'(wt.size()), 32'd12);
        end

        // FIFO full for 5 cycles after 2 beats of a 6-beat burst.
        run_burst(3, 'h40, 6, 1'b1, 2, -1, 4'h0);
        chk_wq("stall", 'h40, 6);

        // Requester 1 abandons after 2 beats; requester 3 pending.
        run_burst(1, 'h50, 10, 1'b1, -1, 2, 4'b1000);
        chk_wq("abandon", 'h50, 2);
        if (t_drop >= 0) begin
            chk("abandon_drop_cycle_gnt", 32'(ghist[t_drop]), 32'h2);
            chk("abandon_idle_gnt", 32'(ghist[t_drop + 1]), 32'h0);
            chk("abandon_next_gnt", 32'(ghist[t_drop + 2]), 32'h8);
        end else begin
            chk("abandon_seen", 32'h0, 32'h1);
        end
        @(posedge clk_wr); #1;

        // Reset during beat 3 of a requester-0 burst.
        req = 4'h1; req_last = '0; req_data = '0; k = 0; acc = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk_wr); #1;
            if (acc) k++;
            req_data[7:0] = 8'(8'h60 + k);
            if (k == 3) break;
            @(negedge clk_wr);
            acc = ack[0] & req[0];
        end
        chk("mr_reached_beat3", 32'(k), 32'd3);
        reset_n = 1'b0;
        @(negedge clk_wr);
        chk("mr_rst_wr_en", 32'(wr_en), 32'h0);
        chk("mr_rst_ack", 32'(ack), 32'h0);
        @(posedge clk_wr); #1;
        reset_n = 1'b1; req = 4'hF; req_last = 4'hF;
        @(negedge clk_wr);
        chk("mr_after_gnt", 32'(gnt), 32'h0);
        chk("mr_after_wr_en", 32'(wr_en), 32'h0);
        @(posedge clk_wr); #1;
        @(negedge clk_wr);
        chk("mr_first_gnt", 32'(gnt), 32'h1);
        @(posedge clk_wr); #1;
        req = '0; req_last = '0;

        // Randomized traffic: variable bursts, gaps, abandons, full, rare resets.
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; pos[i] = 0; gap[i] = 0; base[i] = '0;
        end
        accr = '0;
        repeat (4000) begin
            @(posedge clk_wr); #1;
            reset_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (accr[i]) begin
                    pos[i]++; rem[i]--;
                    if (rem[i] == 0) gap[i] = $urandom_range(0, 3);
                end
                if (rem[i] == 0) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        rem[i] = $urandom_range(1, 12); pos[i] = 0; base[i] = DW'($urandom);
                    end
                end else if (gnt[i] && $urandom_range(0, 39) == 0) begin
                    rem[i] = 0; gap[i] = 2;
                end
                req[i] = (rem[i] > 0);
                req_last[i] = (rem[i] == 1) && ($urandom_range(0, 5) != 0);
                req_data[i*DW +: DW] = DW'(base[i] + DW'(pos[i]));
            end
            w_full = ($urandom_range(0, 4) == 0);
            @(negedge clk_wr);
            accr = ack & req;
        end

        @(posedge clk_wr); #1;
        req = '0; req_last = '0; w_full = 1'b0; reset_n = 1'b1;
        repeat (2) @(negedge clk_wr);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
